// File: rtl/codec_capture_pkg.sv
// Shared audio constants for the codec capture path.
package codec_capture_pkg;
  localparam int SAMPLE_WIDTH = 18;
  localparam int FIFO_DEPTH   = 8;

  // fill_level needs one more bit than the pointers so a full FIFO is representable
  function automatic int level_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/codec_capture_if.sv
// Frame/sample/consumer signal bundle between the codec capture block and its environment.
interface codec_capture_if
  import codec_capture_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
);
  localparam int LW = level_bits(DEPTH);

  logic             new_frame;
  logic [WIDTH-1:0] codec_sample;
  logic [WIDTH-1:0] sample_out;
  logic             sample_valid;
  logic             sample_ready;
  logic [LW-1:0]    fill_level;
  logic             overflow;
  logic             clear_overflow;

  modport master (
    output new_frame, codec_sample, sample_ready, clear_overflow,
    input  sample_out, sample_valid, fill_level, overflow
  );

  modport slave (
    input  new_frame, codec_sample, sample_ready, clear_overflow,
    output sample_out, sample_valid, fill_level, overflow
  );
endinterface

// File: rtl/codec_capture_sync_fifo.sv
// Power-of-two synchronous FIFO with combinational head read; contents survive reset.
module sync_fifo
  import codec_capture_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic                        full,
  output logic                        empty,
  output logic [level_bits(DEPTH)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign w_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign w_push = push & (~full | w_pop);
  assign dout   = r_mem[r_rd_ptr];
  assign count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/codec_capture.sv
// Captures one codec sample per rising edge of new_frame into a FIFO, flagging dropped samples.
module codec_capture
  import codec_capture_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  codec_capture_if.slave  bus
);
  logic                         r_prev_frame;
  logic                         r_overflow;
  logic                         w_capture;
  logic                         w_pop;
  logic                         w_drop;
  logic                         w_full;
  logic                         w_empty;
  logic [WIDTH-1:0]             w_dout;
  logic [level_bits(DEPTH)-1:0] w_count;

  assign w_capture = bus.new_frame & ~r_prev_frame;
  assign w_pop     = ~w_empty & bus.sample_ready;
  assign w_drop    = w_capture & w_full & ~w_pop;

  assign bus.sample_out   = w_dout;
  assign bus.sample_valid = ~w_empty;
  assign bus.fill_level   = w_count;
  assign bus.overflow     = r_overflow;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_capture),
    .pop   (bus.sample_ready),
    .din   (bus.codec_sample),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // prev_frame resets high so a strobe already asserted at release is not taken as an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_frame <= 1'b1;
      r_overflow   <= 1'b0;
    end else begin
      r_prev_frame <= bus.new_frame;
      if (w_drop)                  r_overflow <= 1'b1;
      else if (bus.clear_overflow) r_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_codec_capture.sv
// Bench for codec_capture: table vectors, directed corner sequences and random traffic against a queue model.
module tb_codec_capture;
  localparam int W  = 18;
  localparam int D  = 8;
  localparam int LW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  codec_capture_if #(.WIDTH(W), .DEPTH(D)) bus ();

  codec_capture #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: a queue of samples in capture order
  logic [W-1:0] m_q[$];
  logic         m_prev;
  logic         m_ovf;

  typedef struct {
    logic         nf;
    logic [W-1:0] data;
    logic         rdy;
    logic         clr;
    logic         exp_valid;
    logic [W-1:0] exp_out;
    int           exp_level;
    logic         exp_ovf;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev = 1'b1;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step(input logic nf, input logic [W-1:0] d, input logic rdy, input logic clr);
    bit edge_s, pop, push, drop;
    edge_s = nf && !m_prev;
    pop    = (m_q.size() > 0) && rdy;
    push   = edge_s && ((m_q.size() < D) || pop);
    drop   = edge_s && !push;
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    m_prev = nf;
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(bus.sample_valid), 32'(m_q.size() != 0));
    chk({tag, ".level"}, 32'(bus.fill_level), 32'(m_q.size()));
    chk({tag, ".ovf"},   32'(bus.overflow), 32'(m_ovf));
    if (m_q.size() != 0) chk({tag, ".out"}, 32'(bus.sample_out), 32'(m_q[0]));
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge
  task automatic cycle(input logic nf, input logic [W-1:0] d, input logic rdy, input logic clr, input string tag);
    @(negedge clk);
    bus.new_frame      = nf;
    bus.codec_sample   = d;
    bus.sample_ready   = rdy;
    bus.clear_overflow = clr;
    model_step(nf, d, rdy, clr);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic capture(input logic [W-1:0] d, input string tag);
    cycle(1'b1, d, 1'b0, 1'b0, tag);
    cycle(1'b0, d, 1'b0, 1'b0, tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * D + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    bus.new_frame      = 1'b0;
    bus.codec_sample   = '0;
    bus.sample_ready   = 1'b0;
    bus.clear_overflow = 1'b0;
    model_reset();

    tbl[0]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 18'h00000, 0, 1'b0};
    tbl[1]  = '{1'b1, 18'h00123, 1'b0, 1'b0, 1'b1, 18'h00123, 1, 1'b0};
    tbl[2]  = '{1'b1, 18'h00123, 1'b0, 1'b0, 1'b1, 18'h00123, 1, 1'b0};
    tbl[3]  = '{1'b1, 18'h00123, 1'b0, 1'b0, 1'b1, 18'h00123, 1, 1'b0};
    tbl[4]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b1, 18'h00123, 1, 1'b0};
    tbl[5]  = '{1'b1, 18'h00002, 1'b0, 1'b0, 1'b1, 18'h00123, 2, 1'b0};
    tbl[6]  = '{1'b0, 18'h00000, 1'b0, 1'b0, 1'b1, 18'h00123, 2, 1'b0};
    tbl[7]  = '{1'b1, 18'h00003, 1'b0, 1'b0, 1'b1, 18'h00123, 3, 1'b0};
    tbl[8]  = '{1'b0, 18'h00000, 1'b1, 1'b0, 1'b1, 18'h00002, 2, 1'b0};
    tbl[9]  = '{1'b0, 18'h00000, 1'b1, 1'b0, 1'b1, 18'h00003, 1, 1'b0};
    tbl[10] = '{1'b0, 18'h00000, 1'b1, 1'b0, 1'b0, 18'h00000, 0, 1'b0};
    tbl[11] = '{1'b0, 18'h00000, 1'b1, 1'b1, 1'b0, 18'h00000, 0, 1'b0};

    // Reset state
    #2;
    chk("rst.valid", 32'(bus.sample_valid), 32'd0);
    chk("rst.level", 32'(bus.fill_level), 32'd0);
    chk("rst.ovf",   32'(bus.overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table vectors: single capture, hold, ordered drain, ready while empty
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].nf, tbl[i].data, tbl[i].rdy, tbl[i].clr, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.valid_t", i), 32'(bus.sample_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d.level_t", i), 32'(bus.fill_level), 32'(tbl[i].exp_level));
      chk($sformatf("tbl%0d.ovf_t", i),   32'(bus.overflow), 32'(tbl[i].exp_ovf));
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d.out_t", i), 32'(bus.sample_out), 32'(tbl[i].exp_out));
      $display("vec %0d nf=%0b d=%0h rdy=%0b -> valid=%0b out=%0h level=%0d ovf=%0b",
               i, tbl[i].nf, tbl[i].data, tbl[i].rdy, bus.sample_valid, bus.sample_out, bus.fill_level, bus.overflow);
    end

    // Long strobe: one push only
    for (int i = 0; i < 500; i++) cycle(1'b1, 18'h00123, 1'b0, 1'b0, "hold");
    chk("hold.level_t", 32'(bus.fill_level), 32'd1);
    chk("hold.out_t", 32'(bus.sample_out), 32'h00123);
    cycle(1'b0, '0, 1'b0, 1'b0, "hold");
    drain("hold_drain");

    // Overflow: 9 captures into depth 8, then drain 1..8, then clear
    for (int v = 1; v <= 9; v++) capture(W'(v), "ovf_fill");
    chk("ovf.level_t", 32'(bus.fill_level), 32'(D));
    chk("ovf.flag_t", 32'(bus.overflow), 32'd1);
    for (int v = 1; v <= 8; v++) begin
      chk("ovf.drain_t", 32'(bus.sample_out), 32'(v));
      cycle(1'b0, '0, 1'b1, 1'b0, "ovf_drain");
    end
    chk("ovf.empty_t", 32'(bus.sample_valid), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b1, "ovf_clr");
    chk("ovf.cleared_t", 32'(bus.overflow), 32'd0);

    // Drop and clear in the same cycle: set wins
    for (int v = 0; v < D; v++) capture(W'(v + 32), "setwins_fill");
    cycle(1'b1, 18'h00077, 1'b0, 1'b1, "setwins");
    chk("setwins.flag_t", 32'(bus.overflow), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, "setwins_clr");
    chk("setwins.cleared_t", 32'(bus.overflow), 32'd0);
    drain("setwins_drain");

    // Full with simultaneous pop: the new sample is accepted and comes out last
    for (int v = 0; v < D; v++) capture(W'(v + 100), "fullpop_fill");
    cycle(1'b1, 18'h3FFFF, 1'b1, 1'b0, "fullpop");
    chk("fullpop.level_t", 32'(bus.fill_level), 32'(D));
    chk("fullpop.ovf_t", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < D - 1; i++) cycle(1'b0, '0, 1'b1, 1'b0, "fullpop_drain");
    chk("fullpop.last_t", 32'(bus.sample_out), 32'h3FFFF);
    drain("fullpop_drain");

    // Asynchronous reset mid-operation with the strobe held high
    for (int v = 0; v < 4; v++) capture(W'(v + 200), "rst_fill");
    cycle(1'b1, 18'h000CC, 1'b0, 1'b0, "rst_fill");
    chk("rst5.level_t", 32'(bus.fill_level), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("arst.valid", 32'(bus.sample_valid), 32'd0);
    chk("arst.level", 32'(bus.fill_level), 32'd0);
    chk("arst.ovf",   32'(bus.overflow), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 18'h000DD, 1'b0, 1'b0, "rst_hold");
    chk("rst_hold.level_t", 32'(bus.fill_level), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b0, "rst_low");
    cycle(1'b1, 18'h000EE, 1'b0, 1'b0, "rst_edge");
    chk("rst_edge.out_t", 32'(bus.sample_out), 32'h000EE);
    cycle(1'b0, '0, 1'b0, 1'b0, "rst_edge");
    drain("rst_drain");

    // Wrap-around: 20 capture/pop pairs
    for (int v = 0; v < 20; v++) begin
      cycle(1'b1, W'(v), 1'b0, 1'b0, "wrap_cap");
      chk("wrap.out_t", 32'(bus.sample_out), 32'(v));
      cycle(1'b0, '0, 1'b1, 1'b0, "wrap_pop");
    end
    chk("wrap.ovf_t", 32'(bus.overflow), 32'd0);
    chk("wrap.level_t", 32'(bus.fill_level), 32'd0);

    // Random traffic: strobe toggles at random intervals, data changes only on rising strobe
    begin
      logic         nf;
      logic [W-1:0] d;
      int           hold;
      nf = 1'b0;
      d  = '0;
      hold = 1;
      for (int i = 0; i < 3000; i++) begin
        hold--;
        if (hold == 0) begin
          nf = ~nf;
          if (nf) d = W'($urandom);
          hold = int'($urandom_range(1, 6));
        end
        cycle(nf, d, ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0), "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/codec_capture.md
CODEC_CAPTURE -- requirements
Module: codec_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 18, the sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, the number of FIFO entries; it must be a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port new_frame, input, 1 bit: codec frame strobe, high for many clk cycles per 48 kHz frame.
REQ-006 SHALL have port codec_sample, input, WIDTH bits: ADC sample from the codec, stable while new_frame is high.
REQ-007 SHALL have port sample_out, output, WIDTH bits: the oldest buffered sample (FIFO head).
REQ-008 SHALL have port sample_valid, output, 1 bit: sample_out holds a buffered sample.
REQ-009 SHALL have port sample_ready, input, 1 bit: the consumer accepts sample_out this cycle.
REQ-010 SHALL have port fill_level, output, log2(DEPTH)+1 bits: number of buffered samples.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag meaning a captured sample was dropped.
REQ-012 SHALL have port clear_overflow, input, 1 bit: clears overflow.

Function
REQ-013 SHALL register new_frame as prev_frame and define capture = new_frame AND NOT prev_frame, combinationally, for one cycle per rising edge.
REQ-014 SHALL push codec_sample on capture when fill_level < DEPTH, or when fill_level = DEPTH and a pop occurs in the same cycle.
REQ-015 SHALL pop when sample_valid = 1 and sample_ready = 1; sample_ready while sample_valid = 0 has no effect.
REQ-016 SHALL drive sample_valid = 1 exactly when fill_level != 0.
REQ-017 SHALL drive sample_out = mem[rd_ptr]; its value is don't-care while sample_valid = 0.
REQ-018 SHALL make a pushed sample visible on sample_out and sample_valid on the clk edge after the capture cycle, a latency of 1 cycle into an empty FIFO.
REQ-019 SHALL update fill_level as follows: +1 on push only, -1 on pop only, unchanged on push with pop or on neither.
REQ-020 SHALL advance wr_ptr and rd_ptr modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-021 SHALL discard codec_sample on capture when fill_level = DEPTH with no pop, leave the FIFO contents unchanged, and set overflow on the next edge.
REQ-022 SHALL clear overflow on the next edge when clear_overflow = 1; if a drop and clear_overflow occur in the same cycle, overflow SHALL be 1 (set wins).
REQ-023 SHALL deliver samples in capture order, with no duplication and no loss other than per REQ-021.

Reset
REQ-024 SHALL, while reset = 1 and independent of clk, force wr_ptr = 0, rd_ptr = 0, fill_level = 0, sample_valid = 0, overflow = 0 and prev_frame = 1.
REQ-025 SHALL NOT capture when new_frame is already high at reset release; the first capture is the next rising edge of new_frame.
REQ-026 SHALL NOT reset the sample memory; reset mid-operation discards all buffered samples.

Structure
REQ-027 SHALL place the sample width constant (18) and the default FIFO depth (8) in the shared audio package.
REQ-028 SHALL implement the storage as one sub-module, sync_fifo, with push/pop/full/empty/count; codec_capture contains the edge detector and the overflow flag.

Verification
REQ-029 Single capture: new_frame 0->1 held 500 cycles, codec_sample=18'h00123, sample_ready=0 -> exactly one push; next cycle sample_valid=1, sample_out=18'h00123, fill_level=1.
REQ-030 Ordered drain: capture 18'h1, 18'h2, 18'h3, then sample_ready=1 -> sample_out reads 1, 2, 3 on consecutive cycles; then sample_valid=0 and fill_level=0.
REQ-031 Overflow: 9 captures (values 1..9) with sample_ready=0 and DEPTH=8 -> fill_level=8, overflow=1; drain yields 1..8 only; clear_overflow pulse -> overflow=0.
REQ-032 Full with simultaneous pop: fill_level=8, capture of 18'h3FFFF in the same cycle as a pop -> fill_level stays 8, overflow stays 0, and 18'h3FFFF is the last sample out.
REQ-033 Reset: assert reset asynchronously between edges with fill_level=5 and new_frame=1 -> outputs go to 0 immediately; after release with new_frame still high there is no push until new_frame 0->1.
REQ-034 Wrap-around: 20 interleaved capture/pop pairs with values 0..19 -> pointers wrap twice, output sequence is 0..19, overflow stays 0.
